// File: rtl/key_debounce_pair_pkg.sv
// Shared definitions for the two-channel key debouncer: FSM state
// encoding and the default stability window length.
package key_debounce_pair_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/key_debounce_pair_chan.sv
// One debounce channel: two-flop synchroniser, stability counter and
// press/release FSM producing a registered clean level.
// Optional macro KEY_DEBOUNCE_PULSE_EN adds a single-cycle press pulse.
module key_debounce_chan
  import key_debounce_pair_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw,
  output logic       clean,
  output logic [1:0] state
`ifdef KEY_DEBOUNCE_PULSE_EN
  ,
  output logic       press
`endif
);

  // Terminal count: the input has been stable for DEBOUNCE_CYCLES cycles.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clean_q, clean_d;
  logic             press_d;

  // Next-state logic: a level change must persist until the counter
  // reaches its terminal value before the clean output follows it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    press_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          state_d = PRESSED;
          clean_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!s2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          clean_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Synchroniser, counter and FSM registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign clean = clean_q;
  assign state = state_q;

`ifdef KEY_DEBOUNCE_PULSE_EN
  logic press_q;

  // Registered pulse aligned with the first cycle clean is high.
  always_ff @(posedge clk) begin
    if (reset) press_q <= 1'b0;
    else       press_q <= press_d;
  end

  assign press = press_q;
`else
  logic unused_press;
  assign unused_press = press_d;
`endif

endmodule

// File: rtl/key_debounce_pair.sv
// Two independent debounce channels for the ONE and ZERO keys feeding
// the two-ones/two-zeros detector.
// Optional macro KEY_DEBOUNCE_PULSE_EN adds one_press / zero_press.
module key_debounce_pair
  import key_debounce_pair_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ONE,
  input  logic       ZERO,
  output logic       one_clean,
  output logic       zero_clean,
  output logic [1:0] state_one,
  output logic [1:0] state_zero
`ifdef KEY_DEBOUNCE_PULSE_EN
  ,
  output logic       one_press,
  output logic       zero_press
`endif
);

  key_debounce_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_one (
    .clk  (clk),
    .reset(reset),
    .raw  (ONE),
    .clean(one_clean),
    .state(state_one)
`ifdef KEY_DEBOUNCE_PULSE_EN
    ,
    .press(one_press)
`endif
  );

  key_debounce_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_zero (
    .clk  (clk),
    .reset(reset),
    .raw  (ZERO),
    .clean(zero_clean),
    .state(state_zero)
`ifdef KEY_DEBOUNCE_PULSE_EN
    ,
    .press(zero_press)
`endif
  );

endmodule

// File: tb/tb_key_debounce_pair.sv
// Directed bench for key_debounce_pair with DEBOUNCE_CYCLES=4: a held raw
// level reaches the clean output after edge 6 (edge 0 samples it into s1).
module tb_key_debounce_pair;

  logic       clk;
  logic       reset;
  logic       ONE;
  logic       ZERO;
  logic       one_clean;
  logic       zero_clean;
  logic [1:0] state_one;
  logic [1:0] state_zero;
`ifdef KEY_DEBOUNCE_PULSE_EN
  logic       one_press;
  logic       zero_press;
`endif

  int asserts_cnt;
  int fail_cnt;

  key_debounce_pair #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ONE       (ONE),
    .ZERO      (ZERO),
    .one_clean (one_clean),
    .zero_clean(zero_clean),
    .state_one (state_one),
    .state_zero(state_zero)
`ifdef KEY_DEBOUNCE_PULSE_EN
    ,
    .one_press (one_press),
    .zero_press(zero_press)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge; outputs are stable 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ONE   = 1'b0;
    ZERO  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] exp_state;
    do_reset();
    asserts_cnt++;
    if (one_clean !== 1'b0) begin
      fail_cnt++;
      $display("[TB] FAIL reset_one_clean got=%b exp=0", one_clean);
    end
    asserts_cnt++;
    if (zero_clean !== 1'b0) begin
      fail_cnt++;
      $display("[TB] FAIL reset_zero_clean got=%b exp=0", zero_clean);
    end
    asserts_cnt++;
    if (state_one !== 2'd0) begin
      fail_cnt++;
      $display("[TB] FAIL reset_state_one got=%0d exp=0", state_one);
    end
    asserts_cnt++;
    if (state_zero !== 2'd0) begin
      fail_cnt++;
      $display("[TB] FAIL reset_state_zero got=%0d exp=0", state_zero);
    end
    ONE = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      tick();
      exp_state = (e < 2) ? 2'd0 : ((e < 6) ? 2'd1 : 2'd2);
      asserts_cnt++;
      if (one_clean !== (e >= 6)) begin
        fail_cnt++;
        $display("[TB] FAIL press_one_clean edge=%0d got=%b exp=%b", e, one_clean, (e >= 6));
      end
      asserts_cnt++;
      if (state_one !== exp_state) begin
        fail_cnt++;
        $display("[TB] FAIL press_state_one edge=%0d got=%0d exp=%0d", e, state_one, exp_state);
      end
      asserts_cnt++;
      if (zero_clean !== 1'b0) begin
        fail_cnt++;
        $display("[TB] FAIL press_zero_clean edge=%0d got=%b exp=0", e, zero_clean);
      end
    end
  endtask

  task automatic test_bounce();
    logic [11:0] pat;
    pat = 12'b1111_1110_1101;  // bit i drives edge i: 1,0,1,1,0 then held 1
    do_reset();
    for (int i = 0; i < 12; i++) begin
      ONE = pat[i];
      tick();
      asserts_cnt++;
      if (one_clean !== (i >= 11)) begin
        fail_cnt++;
        $display("[TB] FAIL bounce_one_clean edge=%0d got=%b exp=%b", i, one_clean, (i >= 11));
      end
    end
  endtask

  task automatic test_release();
    logic [11:0] pat;
    pat = 12'b0000_0001_1100;  // 0,0,1,1,1 then held 0; starts from PRESSED
    for (int i = 0; i < 12; i++) begin
      ONE = pat[i];
      tick();
      asserts_cnt++;
      if (one_clean !== (i < 11)) begin
        fail_cnt++;
        $display("[TB] FAIL release_one_clean edge=%0d got=%b exp=%b", i, one_clean, (i < 11));
      end
      if (i == 2) begin
        asserts_cnt++;
        if (state_one !== 2'd3) begin
          fail_cnt++;
          $display("[TB] FAIL release_dip_state edge=%0d got=%0d exp=3", i, state_one);
        end
      end
      if (i == 4) begin
        asserts_cnt++;
        if (state_one !== 2'd2) begin
          fail_cnt++;
          $display("[TB] FAIL release_recover_state edge=%0d got=%0d exp=2", i, state_one);
        end
      end
    end
    asserts_cnt++;
    if (state_one !== 2'd0) begin
      fail_cnt++;
      $display("[TB] FAIL release_final_state got=%0d exp=0", state_one);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    ONE  = 1'b1;
    ZERO = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      tick();
      asserts_cnt++;
      if (one_clean !== (e >= 6)) begin
        fail_cnt++;
        $display("[TB] FAIL simul_one_clean edge=%0d got=%b exp=%b", e, one_clean, (e >= 6));
      end
      asserts_cnt++;
      if (zero_clean !== (e >= 6)) begin
        fail_cnt++;
        $display("[TB] FAIL simul_zero_clean edge=%0d got=%b exp=%b", e, zero_clean, (e >= 6));
      end
    end
    do_reset();
    ONE = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      ZERO = (e == 1 || e == 2);
      tick();
      asserts_cnt++;
      if (one_clean !== (e >= 6)) begin
        fail_cnt++;
        $display("[TB] FAIL glitch_one_clean edge=%0d got=%b exp=%b", e, one_clean, (e >= 6));
      end
      asserts_cnt++;
      if (zero_clean !== 1'b0) begin
        fail_cnt++;
        $display("[TB] FAIL glitch_zero_clean edge=%0d got=%b exp=0", e, zero_clean);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ONE = 1'b1;
    for (int e = 0; e <= 4; e++) tick();
    asserts_cnt++;
    if (state_one !== 2'd1) begin
      fail_cnt++;
      $display("[TB] FAIL midreset_pre_state got=%0d exp=1", state_one);
    end
    reset = 1'b1;
    tick();
    asserts_cnt++;
    if (state_one !== 2'd0) begin
      fail_cnt++;
      $display("[TB] FAIL midreset_state got=%0d exp=0", state_one);
    end
    asserts_cnt++;
    if (one_clean !== 1'b0) begin
      fail_cnt++;
      $display("[TB] FAIL midreset_clean got=%b exp=0", one_clean);
    end
    reset = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      tick();
      asserts_cnt++;
      if (one_clean !== (e >= 6)) begin
        fail_cnt++;
        $display("[TB] FAIL midreset_recount edge=%0d got=%b exp=%b", e, one_clean, (e >= 6));
      end
    end
  endtask

`ifdef KEY_DEBOUNCE_PULSE_EN
  task automatic test_pulse();
    int pulses;
    pulses = 0;
    do_reset();
    asserts_cnt++;
    if (one_press !== 1'b0 || zero_press !== 1'b0) begin
      fail_cnt++;
      $display("[TB] FAIL pulse_reset got=%b%b exp=00", one_press, zero_press);
    end
    for (int p = 0; p < 2; p++) begin
      ONE = 1'b1;
      for (int e = 0; e <= 8; e++) begin
        tick();
        if (one_press === 1'b1) pulses++;
        asserts_cnt++;
        if (one_press !== (e == 6)) begin
          fail_cnt++;
          $display("[TB] FAIL pulse_one press=%0d edge=%0d got=%b exp=%b", p, e, one_press, (e == 6));
        end
        asserts_cnt++;
        if (zero_press !== 1'b0) begin
          fail_cnt++;
          $display("[TB] FAIL pulse_zero press=%0d edge=%0d got=%b exp=0", p, e, zero_press);
        end
      end
      ONE = 1'b0;
      for (int e = 0; e <= 9; e++) begin
        tick();
        if (one_press === 1'b1) pulses++;
        asserts_cnt++;
        if (one_press !== 1'b0) begin
          fail_cnt++;
          $display("[TB] FAIL pulse_release press=%0d edge=%0d got=%b exp=0", p, e, one_press);
        end
      end
    end
    asserts_cnt++;
    if (pulses != 2) begin
      fail_cnt++;
      $display("[TB] FAIL pulse_count got=%0d exp=2", pulses);
    end
  endtask
`endif

  initial begin
    asserts_cnt = 0;
    fail_cnt    = 0;
    reset       = 1'b1;
    ONE         = 1'b0;
    ZERO        = 1'b0;
    test_reset();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid();
`ifdef KEY_DEBOUNCE_PULSE_EN
    test_pulse();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts_cnt, fail_cnt);
    $finish;
  end

endmodule
